// File: rtl/reg_file_wb.sv
// Two-read, one-write register file with a hardwired-zero entry 0 and a saturating write counter.
// A clr_req starts a walk that zeroes entries 1..31. Define REG_BYPASS_EN to forward same-cycle write data to the read ports.
module reg_file_wb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic              RegWre,
    input  logic [DATA_W-1:0] write_data,
    input  logic              clr_req,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic              busy,
    output logic [15:0]       wr_count
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              busy_q, busy_d;
    logic [15:0]       wr_count_q, wr_count_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic              wr_accept;

    assign wr_accept = RegWre && (write_reg != '0) && (state_q == IDLE) && !Reset;

    // The clear walk starts at entry 1 because entry 0 never holds anything but zero.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    ptr_d   = FIRST_IDX;
                end
            end
            CLEAR: begin
                ptr_d = ptr_q + FIRST_IDX;
                if (ptr_q == LAST_IDX) begin
                    state_d = IDLE;
                    ptr_d   = FIRST_IDX;
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = FIRST_IDX;
            end
        endcase
        busy_d = (state_d == CLEAR);
    end

    always_comb begin
        wr_count_d = wr_count_q;
        if (wr_accept && (wr_count_q != 16'hFFFF)) begin
            wr_count_d = wr_count_q + 16'd1;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (wr_accept) begin
            mem_d[write_reg] = write_data;
        end
        if (state_q == CLEAR) begin
            mem_d[ptr_q] = '0;
        end
        mem_d[0] = '0;
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            ptr_q      <= FIRST_IDX;
            busy_q     <= 1'b0;
            wr_count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            busy_q     <= busy_d;
            wr_count_q <= wr_count_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    always_comb begin
        read_data1 = mem_q[read_reg1];
        read_data2 = mem_q[read_reg2];
`ifdef REG_BYPASS_EN
        if (wr_accept && (read_reg1 == write_reg)) begin
            read_data1 = write_data;
        end
        if (wr_accept && (read_reg2 == write_reg)) begin
            read_data2 = write_data;
        end
`endif
    end

    assign busy     = busy_q;
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_reg_file_wb.sv
// Scoreboard bench for reg_file_wb: a behavioural model predicts each value, which is queued and then compared with the DUT.
module tb_reg_file_wb;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [4:0]  read_reg1, read_reg2, write_reg;
    logic        RegWre;
    logic [31:0] write_data;
    logic        clr_req;
    logic [31:0] read_data1, read_data2;
    logic        busy;
    logic [15:0] wr_count;

    reg_file_wb #(.DATA_W(32), .ADDR_W(5)) dut (
        .CLK(CLK), .Reset(Reset),
        .read_reg1(read_reg1), .read_reg2(read_reg2), .write_reg(write_reg),
        .RegWre(RegWre), .write_data(write_data), .clr_req(clr_req),
        .read_data1(read_data1), .read_data2(read_data2),
        .busy(busy), .wr_count(wr_count)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_mem [32];
    logic [15:0] m_count;
    logic        m_busy;
    logic [4:0]  m_ptr;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;
    exp_t sbq[$];

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic pushExp(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sbq.push_back(e);
    endtask

    task automatic popCheck(input logic [31:0] act);
        exp_t e;
        if (sbq.size() == 0) begin
            checkOutput("sb_empty", 32'(sbq.size()), 32'd1);
        end else begin
            e = sbq.pop_front();
            checkOutput(e.tag, act, e.exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 32; i++) m_mem[i] = '0;
        m_count = '0;
        m_busy  = 1'b0;
        m_ptr   = 5'd1;
    endtask

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic modelEdge();
        if (!Reset) begin
            if (RegWre && write_reg != 5'd0 && !m_busy) begin
                m_mem[write_reg] = write_data;
                if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
            end
            if (m_busy) begin
                m_mem[m_ptr] = '0;
                if (m_ptr == 5'd31) m_busy = 1'b0;
                else m_ptr = m_ptr + 5'd1;
            end else if (clr_req) begin
                m_busy = 1'b1;
                m_ptr  = 5'd1;
            end
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [4:0] wr, input logic [31:0] wd, input logic clr);
        RegWre     = we;
        write_reg  = wr;
        write_data = wd;
        clr_req    = clr;
    endtask

    task automatic tick();
        modelEdge();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic checkRead1(input string tag, input logic [4:0] idx);
        read_reg1 = idx;
        pushExp(tag, m_mem[idx]);
        #1;
        popCheck(read_data1);
    endtask

    task automatic checkRead2(input string tag, input logic [4:0] idx);
        read_reg2 = idx;
        pushExp(tag, m_mem[idx]);
        #1;
        popCheck(read_data2);
    endtask

    task automatic checkCount(input string tag);
        pushExp(tag, 32'(m_count));
        popCheck(32'(wr_count));
    endtask

    task automatic checkBusy(input string tag);
        pushExp(tag, 32'(m_busy));
        popCheck(32'(busy));
    endtask

    task automatic checkAllEntries(input string tag);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
        for (int i = 0; i < 32; i++) begin
            checkRead1(tag, 5'(i));
            tick();
        end
    endtask

    task automatic fillIndex(input logic [31:0] xorv);
        for (int i = 1; i < 32; i++) begin
            applyStimulus(1'b1, 5'(i), 32'(i) ^ xorv, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
    endtask

    task automatic doReset();
        @(negedge CLK);
        #2;
        Reset = 1'b1;
        modelReset();
        @(negedge CLK);
        Reset = 1'b0;
    endtask

    int n;

    initial begin
        Reset = 1'b1;
        read_reg1 = '0;
        read_reg2 = '0;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
        modelReset();
        #12;
        checkBusy("reset_busy");
        checkCount("reset_count");
        checkRead1("reset_entry5", 5'd5);
        @(negedge CLK);
        Reset = 1'b0;

        // Basic write then read back
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
        checkRead1("wr5_read", 5'd5);
        checkCount("wr5_count");

        // Same-cycle read of the entry being written
        applyStimulus(1'b1, 5'd3, 32'h55, 1'b0);
        read_reg1 = 5'd3;
`ifdef REG_BYPASS_EN
        pushExp("bypass_before_edge", 32'h55);
`else
        pushExp("nobypass_before_edge", m_mem[3]);
`endif
        #1;
        popCheck(read_data1);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
        checkRead1("wr3_after_edge", 5'd3);

        // Writes to entry 0 are discarded and not counted
        applyStimulus(1'b1, 5'd0, 32'h12345678, 1'b0);
        checkRead2("entry0_same_cycle", 5'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
        checkRead2("entry0_read", 5'd0);
        checkCount("entry0_count");

        // Full fill, then clear with a dropped write and an ignored clr_req
        doReset();
        fillIndex(32'd0);
        checkRead1("fill_entry31", 5'd31);
        checkCount("fill_count");
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
        tick();
        n = 0;
        while (busy && n < 64) begin
            n++;
            if (n == 10) applyStimulus(1'b1, 5'd7, 32'hAAAA5555, 1'b0);
            else if (n == 15) applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
            else applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
            if (n == 5) begin
                checkRead1("clr_read_done", 5'd2);
                checkRead2("clr_read_pending", 5'd20);
            end
            tick();
        end
        checkOutput("busy_cycles", 32'(n), 32'd31);
        checkBusy("clr_done_busy");
        checkCount("clr_count");
        checkAllEntries("clr_entry");

        // Write coincident with clr_req, then async reset at clear cycle 10
        fillIndex(32'hA5A50000);
        applyStimulus(1'b1, 5'd4, 32'h44, 1'b1);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
        checkCount("coincident_count");
        checkBusy("coincident_busy");
        n = 0;
        while (busy && n < 9) begin
            n++;
            tick();
        end
        checkOutput("pre_abort_busy", 32'(busy), 32'd1);
        #2;
        Reset = 1'b1;
        modelReset();
        #1;
        checkBusy("abort_busy");
        checkCount("abort_count");
        checkRead1("abort_entry20", 5'd20);
        applyStimulus(1'b1, 5'd9, 32'hBAD, 1'b0);
        tick();
        checkRead2("reset_write_entry9", 5'd9);
        checkAllEntries("abort_entry");
        @(negedge CLK);
        Reset = 1'b0;
        checkCount("post_reset_count");
        applyStimulus(1'b1, 5'd9, 32'h1, 1'b0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
        checkRead1("post_reset_entry9", 5'd9);
        checkCount("post_reset_count1");
        checkBusy("post_reset_busy");

        // Counter saturation
        doReset();
        for (int i = 0; i < 65534; i++) begin
            applyStimulus(1'b1, 5'((i % 31) + 1), 32'(i), 1'b0);
            tick();
        end
        checkCount("count_fffe");
        applyStimulus(1'b1, 5'd1, 32'h1, 1'b0);
        tick();
        checkCount("count_ffff");
        applyStimulus(1'b1, 5'd2, 32'h2, 1'b0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
        checkCount("count_saturated");
        checkOutput("count_saturated_const", 32'(wr_count), 32'h0000FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
